// File: rtl/out_uart_hex.sv
// Serial trace of the core's 16-bit output register: each new value is sent
// as four uppercase ASCII hex digits plus CR LF on an 8N1 UART line.
module out_uart_hex #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_data,
    output logic        o_tx,
    output logic        o_busy
);

    localparam int             CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_CHAR = 3'd5;
    localparam logic [2:0]     LAST_BIT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state, state_nx;
    logic [15:0]     last_sent, last_sent_nx;
    logic [15:0]     snapshot, snapshot_nx;
    logic [2:0]      char_idx, char_idx_nx;
    logic [2:0]      bit_idx, bit_idx_nx;
    logic [2:0]      bit_idx_inc;
    logic [CW-1:0]   baud_cnt, baud_nx;
    logic            tx_nx, busy_nx;
    logic            baud_wrap;
    logic [7:0]      cur_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'hA:    code = 8'h41;
            4'hB:    code = 8'h42;
            4'hC:    code = 8'h43;
            4'hD:    code = 8'h44;
            4'hE:    code = 8'h45;
            4'hF:    code = 8'h46;
            default: code = {4'h3, nib};
        endcase
        return code;
    endfunction

    // Character currently on the wire, chosen from the frozen snapshot.
    always_comb begin
        case (char_idx)
            3'd0:    cur_char = hex_ascii(snapshot[15:12]);
            3'd1:    cur_char = hex_ascii(snapshot[11:8]);
            3'd2:    cur_char = hex_ascii(snapshot[7:4]);
            3'd3:    cur_char = hex_ascii(snapshot[3:0]);
            3'd4:    cur_char = 8'h0D;
            default: cur_char = 8'h0A;
        endcase
    end

    assign baud_wrap   = (baud_cnt == BAUD_MAX);
    assign bit_idx_inc = bit_idx + 3'd1;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through the case statement can infer a latch.
        state_nx     = state;
        last_sent_nx = last_sent;
        snapshot_nx  = snapshot;
        char_idx_nx  = char_idx;
        bit_idx_nx   = bit_idx;
        baud_nx      = baud_cnt;
        tx_nx        = o_tx;
        busy_nx      = o_busy;

        case (state)
            IDLE: begin
                baud_nx = '0;
                if (i_data != last_sent) begin
                    snapshot_nx  = i_data;
                    last_sent_nx = i_data;
                    char_idx_nx  = 3'd0;
                    bit_idx_nx   = 3'd0;
                    state_nx     = START;
                    tx_nx        = 1'b0;
                    busy_nx      = 1'b1;
                end
            end

            START: begin
                if (baud_wrap) begin
                    baud_nx    = '0;
                    bit_idx_nx = 3'd0;
                    state_nx   = DATA;
                    tx_nx      = cur_char[0];
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                if (baud_wrap) begin
                    baud_nx = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        bit_idx_nx = bit_idx_inc;
                        tx_nx      = cur_char[bit_idx_inc];
                    end
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end

            STOP: begin
                if (baud_wrap) begin
                    baud_nx = '0;
                    if (char_idx == LAST_CHAR) begin
                        // Busy drops on the edge that closes the last stop bit.
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                    end else begin
                        char_idx_nx = char_idx + 3'd1;
                        state_nx    = START;
                        tx_nx       = 1'b0;
                    end
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
                tx_nx    = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            last_sent <= 16'h0000;
            snapshot  <= 16'h0000;
            char_idx  <= 3'd0;
            bit_idx   <= 3'd0;
            baud_cnt  <= '0;
            o_tx      <= 1'b1;
            o_busy    <= 1'b0;
        end else begin
            state     <= state_nx;
            last_sent <= last_sent_nx;
            snapshot  <= snapshot_nx;
            char_idx  <= char_idx_nx;
            bit_idx   <= bit_idx_nx;
            baud_cnt  <= baud_nx;
            o_tx      <= tx_nx;
            o_busy    <= busy_nx;
        end
    end

endmodule

// File: tb/tb_out_uart_hex.sv
// Self-checking bench for out_uart_hex: a frame-level reference model predicts
// the line every cycle, and a UART receiver decodes the bytes actually sent.
module tb_out_uart_hex;

    localparam int CPB   = 4;
    localparam int FRAME = 60 * CPB;

    logic        i_clk  = 1'b0;
    logic        i_rst  = 1'b1;
    logic [15:0] i_data = 16'h0000;
    logic        o_tx;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    out_uart_hex #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (i_data),
        .o_tx   (o_tx),
        .o_busy (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_char(input logic [15:0] v, input int c);
        int nib;
        if (c == 4) return 8'h0D;
        if (c == 5) return 8'h0A;
        nib = (int'(v) >> (12 - 4 * c)) & 15;
        if (nib < 10) return 8'(48 + nib);   // '0' + n
        return 8'(65 + nib - 10);            // 'A' + n - 10
    endfunction

    // Expected line level at cycle pos (0..FRAME-1) of a frame carrying v.
    function automatic logic ref_line(input logic [15:0] v, input int pos);
        int         c, b;
        logic [7:0] ch;
        c  = pos / (10 * CPB);
        b  = (pos / CPB) % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        ch = ref_char(v, c);
        return ch[b-1];
    endfunction

    logic [15:0] m_last = 16'h0000;
    logic [15:0] m_val  = 16'h0000;
    int          m_pos  = -1;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_last <= 16'h0000;
            m_pos  <= -1;
        end else if (m_pos < 0) begin
            if (i_data != m_last) begin
                m_last <= i_data;
                m_val  <= i_data;
                m_pos  <= 0;
            end
        end else if (m_pos == FRAME - 1) begin
            m_pos <= -1;
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    always @(negedge i_clk) begin
        check("tx_vs_model",   o_tx,   (m_pos < 0) ? 1'b1 : ref_line(m_val, m_pos));
        check("busy_vs_model", o_busy, (m_pos >= 0) ? 1'b1 : 1'b0);
    end

    // ---------------- UART receiver and line-gap monitor ----------------
    logic       rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_sh     = 8'h00;
    logic       tx_prev   = 1'b1;
    logic       busy_prev = 1'b0;
    int         hi_run    = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always @(negedge i_clk) begin
        if (i_rst) begin
            rx_active <= 1'b0;
        end else if (!rx_active) begin
            if (!o_tx && tx_prev) begin
                rx_active <= 1'b1;
                rx_cnt    <= 1;
            end
        end else begin
            if (rx_cnt == CPB / 2)
                check("start_bit", o_tx, 1'b0);
            if ((rx_cnt % CPB) == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
                rx_sh[rx_cnt / CPB - 1] <= o_tx;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                check("stop_bit", o_tx, 1'b1);
                rx_q.push_back(rx_sh);
                rx_active <= 1'b0;
            end
            rx_cnt <= rx_cnt + 1;
        end

        if (o_tx) begin
            hi_run <= hi_run + 1;
        end else begin
            if (tx_prev && o_busy && !busy_prev)
                check("frame_gap", (hi_run >= CPB + 1) ? 1'b1 : 1'b0, 1'b1);
            hi_run <= 0;
        end
        tx_prev   <= o_tx;
        busy_prev <= o_busy;
    end

    // ---------------- helpers ----------------
    task automatic push_exp(input logic [15:0] v);
        for (int c = 0; c < 6; c++) exp_q.push_back(ref_char(v, c));
    endtask

    task automatic compare_rx(input string tag);
        int n;
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle();
        int t = 0;
        while (o_busy && t < 4 * FRAME) begin
            t++;
            @(negedge i_clk);
        end
        check("idle_timeout", o_busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          len;
        logic [15:0] vals[10];
        logic        dup;

        i_rst  = 1'b1;
        i_data = 16'h0000;
        repeat (3) @(negedge i_clk);
        check("reset_tx",   o_tx,   1'b1);
        check("reset_busy", o_busy, 1'b0);
        i_rst = 1'b0;

        // Quiet line.
        repeat (1000) @(negedge i_clk);
        check("quiet_rx",   rx_q.size(), 0);
        check("quiet_busy", o_busy, 1'b0);

        // Single frame.
        i_data = 16'h12AB;
        @(negedge i_clk);
        check("start_latency_tx",   o_tx,   1'b0);
        check("start_latency_busy", o_busy, 1'b1);
        len = 0;
        while (o_busy && len < 4 * FRAME) begin
            len++;
            @(negedge i_clk);
        end
        check("busy_len", len, FRAME);
        push_exp(16'h12AB);
        compare_rx("single");

        // Coalescing: two changes during char 2, only the last one is sent.
        i_data = 16'h0001;
        repeat (90) @(negedge i_clk);
        i_data = 16'h0000;
        repeat (5) @(negedge i_clk);
        i_data = 16'h00FF;
        wait_idle();
        check("coalesce_idle_tx", o_tx, 1'b1);
        @(negedge i_clk);
        check("followup_tx",   o_tx,   1'b0);
        check("followup_busy", o_busy, 1'b1);
        wait_idle();
        push_exp(16'h0001);
        push_exp(16'h00FF);
        compare_rx("coalesce");

        // Revert during frame: no follow-up.
        i_data = 16'hFFFF;
        repeat (50) @(negedge i_clk);
        i_data = 16'h1234;
        repeat (20) @(negedge i_clk);
        i_data = 16'hFFFF;
        wait_idle();
        repeat (300) @(negedge i_clk);
        check("revert_quiet", o_busy, 1'b0);
        push_exp(16'hFFFF);
        compare_rx("revert");

        // Asynchronous reset during char 3.
        i_data = 16'hBEEF;
        repeat (130) @(negedge i_clk);
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        check("arst_tx",   o_tx,   1'b1);
        check("arst_busy", o_busy, 1'b0);
        repeat (8) @(negedge i_clk);
        i_rst = 1'b0;
        rx_q.delete();
        @(negedge i_clk);
        check("rearm_tx",   o_tx,   1'b0);
        check("rearm_busy", o_busy, 1'b1);
        wait_idle();
        push_exp(16'hBEEF);
        compare_rx("arst");

        // Back-to-back random values, one change every 300 cycles.
        for (int i = 0; i < 10; i++) begin
            do begin
                vals[i] = 16'($urandom);
                dup = (vals[i] == 16'hBEEF);
                for (int j = 0; j < i; j++) if (vals[j] == vals[i]) dup = 1'b1;
            end while (dup);
        end
        for (int i = 0; i < 10; i++) begin
            i_data = vals[i];
            push_exp(vals[i]);
            repeat (300) @(negedge i_clk);
        end
        check("b2b_idle", o_busy, 1'b0);
        compare_rx("b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
